// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants and helpers for the stream multiplexer.
//   MODE_SEL  : mode value selecting the channel given on 'sel'
//   MODE_RR   : mode value selecting channels in round-robin order
//   sel_width : width of a channel index for a given channel count (min 1)
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width for 'ch' channels; never narrower than one bit.
  function automatic int sel_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// -----------------------------------------------------------------------------
// stream_mux_rr_if
// Bundle of the multiplexer's stream-side signals.
//   in_data/in_valid/in_ready : CH input channels, channel k at [k*WIDTH +: WIDTH]
//   mode/sel                  : channel choice (explicit select or round-robin)
//   out_data/out_valid/out_ready/grant : registered output stream + source index
// Modports:
//   master : the side feeding the inputs and consuming the output
//   slave  : the multiplexer side
// -----------------------------------------------------------------------------
interface stream_mux_rr_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 8
) ();

  localparam int SELW = alu_pkg::sel_width(CH);

  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  logic                mode;
  logic [SELW-1:0]     sel;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic [SELW-1:0]     grant;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, grant
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, grant
  );

endinterface

// File: rtl/rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Combinational round-robin search: returns the first requesting channel
// found when scanning ptr+1, ptr+2, ... (modulo CH).
//   req     : per-channel request
//   ptr     : index of the most recently served channel
//   gnt_idx : chosen channel (0 when nothing requests)
//   gnt_any : high when some channel requests
// -----------------------------------------------------------------------------
module rr_arb
  import alu_pkg::*;
#(
  parameter  int CH   = 8,
  localparam int SELW = sel_width(CH)
) (
  input  logic [CH-1:0]   req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  always_comb begin
    int cand;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    // Walk from the farthest offset to the nearest so the nearest requester
    // after ptr is the last one written and therefore wins.
    for (int i = CH; i >= 1; i--) begin
      cand = (int'(ptr) + i) % CH;
      if (req[cand]) begin
        gnt_idx = SELW'(cand);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// Multiplexes CH valid/ready input streams onto one registered output stream.
// The channel is chosen either explicitly by 'sel' or in round-robin order.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_data/in_valid      : CH input channels (channel k at [k*WIDTH +: WIDTH])
//   in_ready              : one-hot (or zero) ready back to the chosen channel
//   mode, sel             : 0 = explicit channel 'sel', 1 = round-robin
//   out_data/out_valid    : output register contents
//   out_ready             : downstream accepts the held word
//   grant                 : source channel of the word in the output register
// -----------------------------------------------------------------------------
module stream_mux_rr
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int CH    = 8,
  localparam int SELW  = sel_width(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SELW-1:0]     grant
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  grant_q, grant_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load;
  logic             xfer;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic [SELW-1:0]  pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] word_mux;

  rr_arb #(.CH(CH)) u_rr_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // The output register can take a word when empty or being drained.
  assign load = !valid_q || out_ready;

  // Channel choice depends only on valid, mode, sel and ptr (never on data).
  // An out-of-range explicit select chooses nothing.
  always_comb begin
    pick_idx = sel;
    pick_any = (32'(sel) < 32'(CH));
    if (mode == MODE_RR) begin
      pick_idx = rr_idx;
      pick_any = rr_any;
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ready
      assign in_ready[gi] = !rst && load && pick_any && (pick_idx == SELW'(gi));
    end
  endgenerate

  assign xfer = |(in_valid & in_ready);

  // in_ready is at most one-hot, so it doubles as the data select.
  always_comb begin
    word_mux = '0;
    for (int k = 0; k < CH; k++) begin
      if (in_ready[k]) begin
        word_mux = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      // Covers both an empty register and drain-and-reload in one cycle.
      data_d  = word_mux;
      grant_d = pick_idx;
      valid_d = 1'b1;
      if (mode == MODE_RR) begin
        ptr_d = pick_idx;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      // Last-served = CH-1 makes channel 0 the first round-robin candidate.
      ptr_q   <= SELW'(CH - 1);
    end else begin
      data_q  <= data_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
// Directed scenarios followed by random traffic on an 8-channel instance,
// each cycle compared with a behavioural model; a 6-channel instance covers
// the out-of-range explicit select.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int CA = 8;
  localparam int CB = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(W), .CH(CA)) a_if ();
  stream_mux_rr_if #(.WIDTH(W), .CH(CB)) b_if ();

  stream_mux_rr #(.WIDTH(W), .CH(CA)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_if.in_data), .in_valid(a_if.in_valid), .in_ready(a_if.in_ready),
    .mode(a_if.mode), .sel(a_if.sel),
    .out_data(a_if.out_data), .out_valid(a_if.out_valid),
    .out_ready(a_if.out_ready), .grant(a_if.grant)
  );

  stream_mux_rr #(.WIDTH(W), .CH(CB)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_if.in_data), .in_valid(b_if.in_valid), .in_ready(b_if.in_ready),
    .mode(b_if.mode), .sel(b_if.sel),
    .out_data(b_if.out_data), .out_valid(b_if.out_valid),
    .out_ready(b_if.out_ready), .grant(b_if.grant)
  );

  // Behavioural model of the 8-channel instance.
  int         m_ptr;
  logic       m_valid;
  logic [W-1:0] m_data;
  int         m_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Channel chosen this cycle, -1 for none.
  function automatic int pick_a();
    if (a_if.mode == MODE_SEL) begin
      return (int'(a_if.sel) < CA) ? int'(a_if.sel) : -1;
    end
    for (int i = 1; i <= CA; i++) begin
      if (a_if.in_valid[(m_ptr + i) % CA]) return (m_ptr + i) % CA;
    end
    return -1;
  endfunction

  // One clock of the 8-channel instance: check, clock, advance model.
  task automatic cycle_a();
    int           c;
    logic         ld;
    logic         xf;
    logic         md;
    logic [CA-1:0] exp_rdy;
    logic [W-1:0] w;
    #2;
    c  = pick_a();
    ld = !m_valid || a_if.out_ready;
    md = a_if.mode;
    exp_rdy = '0;
    w  = '0;
    xf = 1'b0;
    if (!rst && c >= 0 && ld) exp_rdy[c] = 1'b1;
    if (c >= 0) begin
      w  = a_if.in_data[c*W +: W];
      xf = !rst && ld && a_if.in_valid[c];
    end
    check("a_in_ready", 64'(a_if.in_ready), 64'(exp_rdy));
    check("a_out_valid", 64'(a_if.out_valid), 64'(m_valid));
    check("a_out_data", 64'(a_if.out_data), 64'(m_data));
    check("a_grant", 64'(a_if.grant), 64'(m_grant));
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_grant = 0;
      m_ptr   = CA - 1;
    end else if (xf) begin
      m_valid = 1'b1;
      m_data  = w;
      m_grant = c;
      if (md == MODE_RR) m_ptr = c;
    end else if (a_if.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int held_g;
    logic [W*CA-1:0] d;

    rst = 1'b1;
    a_if.mode = MODE_SEL; a_if.sel = '0; a_if.in_valid = '0; a_if.in_data = '0; a_if.out_ready = 1'b0;
    b_if.mode = MODE_SEL; b_if.sel = '0; b_if.in_valid = '0; b_if.in_data = '0; b_if.out_ready = 1'b0;
    m_ptr = CA - 1; m_valid = 1'b0; m_data = '0; m_grant = 0;
    @(posedge clk);
    #1;
    // Reset state of both instances.
    #1;
    check("b_rst_in_ready", 64'(b_if.in_ready), 64'(0));
    check("b_rst_out_valid", 64'(b_if.out_valid), 64'(0));
    cycle_a();
    rst = 1'b0;

    // Six channels, explicit select beyond the last channel chooses nothing.
    b_if.mode = MODE_SEL; b_if.in_valid = 6'h3F; b_if.out_ready = 1'b1;
    b_if.in_data = {8'h66, 8'h5B, 8'h44, 8'h33, 8'h22, 8'h11};
    for (int s = 6; s <= 7; s++) begin
      b_if.sel = 3'(s);
      #1;
      check("b_oob_in_ready", 64'(b_if.in_ready), 64'(0));
      cycle_a();
      check("b_oob_out_valid", 64'(b_if.out_valid), 64'(0));
    end
    b_if.sel = 3'd5;
    #1;
    check("b_sel5_in_ready", 64'(b_if.in_ready), 64'(6'h20));
    cycle_a();
    check("b_sel5_out_valid", 64'(b_if.out_valid), 64'(1));
    check("b_sel5_grant", 64'(b_if.grant), 64'(5));
    check("b_sel5_data", 64'(b_if.out_data), 64'(8'h66));

    // Explicit select of channel 5.
    d = {$urandom, $urandom};
    d[5*W +: W] = 8'hA5;
    a_if.in_data = d; a_if.mode = MODE_SEL; a_if.sel = 3'd5;
    a_if.in_valid = 8'h20; a_if.out_ready = 1'b1;
    cycle_a();
    check("sel5_data", 64'(a_if.out_data), 64'(8'hA5));
    check("sel5_grant", 64'(a_if.grant), 64'(5));
    check("sel5_valid", 64'(a_if.out_valid), 64'(1));

    // Round-robin over all channels straight after reset.
    rst = 1'b1;
    cycle_a();
    rst = 1'b0;
    a_if.mode = MODE_RR; a_if.in_valid = 8'hFF; a_if.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_if.in_data = {$urandom, $urandom};
      cycle_a();
      check("rr_all_grant", 64'(a_if.grant), 64'(i % CA));
      check("rr_all_valid", 64'(a_if.out_valid), 64'(1));
    end

    // Park the pointer on channel 4, then alternate between 7 and 4.
    a_if.in_valid = 8'h10;
    cycle_a();
    check("rr_park4", 64'(a_if.grant), 64'(4));
    a_if.in_valid = 8'h90;
    for (int i = 0; i < 4; i++) begin
      cycle_a();
      check("rr_alt_grant", 64'(a_if.grant), 64'(((i % 2) == 0) ? 7 : 4));
    end

    // Backpressure with the register full, then reload without a bubble.
    a_if.in_valid = 8'hFF; a_if.out_ready = 1'b1;
    cycle_a();
    held_g = m_grant;
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_if.in_data = {$urandom, $urandom};
      cycle_a();
      check("bp_hold_grant", 64'(a_if.grant), 64'(held_g));
    end
    a_if.out_ready = 1'b1;
    #2;
    check("bp_release_ready", 64'(a_if.in_ready), 64'(1) << ((held_g + 1) % CA));
    cycle_a();
    check("bp_reload_grant", 64'(a_if.grant), 64'((held_g + 1) % CA));
    check("bp_reload_valid", 64'(a_if.out_valid), 64'(1));

    // Reset while a word is held and not accepted.
    a_if.out_ready = 1'b0;
    cycle_a();
    rst = 1'b1;
    cycle_a();
    check("rst_drop_valid", 64'(a_if.out_valid), 64'(0));
    check("rst_drop_grant", 64'(a_if.grant), 64'(0));
    rst = 1'b0;
    a_if.mode = MODE_RR; a_if.in_valid = 8'h64; a_if.out_ready = 1'b1;
    cycle_a();
    check("rst_first_rr", 64'(a_if.grant), 64'(2));

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      a_if.mode      = 1'($urandom_range(0, 1));
      a_if.sel       = 3'($urandom_range(0, 7));
      a_if.in_valid  = 8'($urandom);
      a_if.in_data   = {$urandom, $urandom};
      a_if.out_ready = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 63) == 0);
      cycle_a();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
